sd_spi_card_responder: RTL and testbench

- Card-side (responder) end of the SD SPI-mode link: behaves as a minimal SD card in SPI mode for loopback testing of the host SD shifter and for bench self-check.
- Samples host-driven sd_clk/sd_cs/sd_mosi in the clk_sys domain, parses 48-bit command frames, checks CRC7, tracks the idle/init state, and returns R1/R3/R7 responses on sd_miso.
- A decoded-command strobe is provided for logging and scoreboards.

---
 rtl/sd_spi_card_responder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sd_spi_card_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
// Module   : sd_spi_card_responder
// Purpose  : Minimal SD card (responder side) in SPI mode 0. Oversamples the
//            host SPI signals in the clk_sys domain, parses 48-bit command
//            frames, checks CRC7, tracks the idle/initialisation state and
//            returns R1/R3/R7 responses on sd_miso.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_sys    in   1  system clock (>= 8x sd_clk)
//   reset_n    in   1  asynchronous active-low reset
//   sd_clk     in   1  SPI clock from host (asynchronous)
//   sd_cs      in   1  chip select from host, active-low
//   sd_mosi    in   1  host-to-card data
//   sd_miso    out  1  card-to-host data
//   card_idle  out  1  R1 idle bit state
//   cmd_valid  out  1  one-cycle pulse per accepted frame
//   cmd_index  out  6  index of last accepted frame
//   cmd_arg    out 32  argument of last accepted frame
//   crc_err    out  1  one-cycle pulse when a frame fails its CRC7 check
// ============================================================================
module sd_spi_card_responder #(
   parameter int NCR_BYTES    = 1,
   parameter int ACMD41_COUNT = 2,
   parameter int CRC_ALWAYS   = 0,
   parameter int CCS          = 1
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        sd_clk,
   input  logic        sd_cs,
   input  logic        sd_mosi,
   output logic        sd_miso,
   output logic        card_idle,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        crc_err
);

   localparam logic [6:0] NCR_BITS    = 7'(NCR_BYTES * 8);
   localparam logic [3:0] ACMD_TARGET = 4'(ACMD41_COUNT);
   localparam logic       CRC_ALL     = (CRC_ALWAYS != 0);
   localparam logic       CCS_BIT     = (CCS != 0);

   typedef enum logic [2:0] {
      S_HUNT  = 3'd0,
      S_RECV  = 3'd1,
      S_CHECK = 3'd2,
      S_NCR   = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   // Reset: asserted asynchronously, released synchronously to clk_sys.
   logic [1:0] rst_sync;
   logic       rst_n_int;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_int = rst_sync[1];

   // Input synchronisers. sclk_sync[2] is the previous synchronised value
   // used for edge detection. MOSI goes through the same depth as sd_clk so
   // the bit seen at a detected rising edge is the one the host launched.
   logic [2:0] sclk_sync;
   logic [1:0] cs_sync;
   logic [1:0] mosi_sync;
   logic       sclk_rise;
   logic       sclk_fall;

   always_ff @(posedge clk_sys or negedge rst_n_int) begin
      if (!rst_n_int) begin
         sclk_sync <= 3'b000;
         cs_sync   <= 2'b11;
         mosi_sync <= 2'b11;
      end else begin
         sclk_sync <= {sclk_sync[1:0], sd_clk};
         cs_sync   <= {cs_sync[0], sd_cs};
         mosi_sync <= {mosi_sync[0], sd_mosi};
      end
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];

   // Serial CRC7, polynomial x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      crc7_step = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   state_t      state;
   logic [46:0] shreg;      // frame bits 46..0; the start bit is implied
   logic [5:0]  bit_cnt;
   logic [6:0]  crc;
   logic [6:0]  ncr_cnt;
   logic [5:0]  resp_cnt;
   logic [39:0] resp;
   logic        resp_long;
   logic        app_cmd;
   logic [3:0]  acmd_cnt;

   logic [5:0]  frame_idx;
   logic [31:0] frame_arg;
   logic        frame_ok;
   logic        crc_bad;
   logic [5:0]  resp_last;

   assign frame_idx = shreg[45:40];
   assign frame_arg = shreg[39:8];
   assign frame_ok  = shreg[46] & shreg[0];
   assign crc_bad   = (CRC_ALL || frame_idx == 6'd0 || frame_idx == 6'd8) &&
                      (shreg[7:1] != crc);
   assign resp_last = resp_long ? 6'd39 : 6'd7;

   // Command decode: next init state and response for an accepted frame.
   logic        nxt_idle;
   logic        nxt_app;
   logic [3:0]  nxt_cnt;
   logic [39:0] nxt_resp;
   logic        nxt_long;

   always_comb begin
      nxt_idle = card_idle;
      nxt_app  = 1'b0;
      nxt_cnt  = acmd_cnt;
      nxt_long = 1'b0;
      nxt_resp = {5'b00000, 1'b1, 1'b0, card_idle, 32'h0};   // illegal command
      case (frame_idx)
         6'd0: begin
            nxt_idle = 1'b1;
            nxt_cnt  = 4'd0;
            nxt_resp = {8'h01, 32'h0};
         end
         6'd8: begin
            nxt_long = 1'b1;
            nxt_resp = {7'b0, card_idle, 16'h0000, 4'h0, frame_arg[11:8], frame_arg[7:0]};
         end
         6'd55: begin
            nxt_app  = 1'b1;
            nxt_resp = {7'b0, card_idle, 32'h0};
         end
         6'd41: begin
            // Without a preceding CMD55 this falls through as illegal.
            if (app_cmd) begin
               nxt_cnt = (acmd_cnt == 4'hF) ? 4'hF : acmd_cnt + 4'd1;
               if (nxt_cnt >= ACMD_TARGET) nxt_idle = 1'b0;
               nxt_resp = {7'b0, nxt_idle, 32'h0};
            end
         end
         6'd58: begin
            // OCR: busy/power-up bit, CCS, reserved bits 29:24 read 0,
            // voltage window 0xFF80 in bits 23:8.
            nxt_long = 1'b1;
            nxt_resp = {7'b0, card_idle, ~card_idle, CCS_BIT, 6'b000000,
                        8'hFF, 8'h80, 8'h00};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state     <= S_HUNT;
         sd_miso   <= 1'b1;
         card_idle <= 1'b1;
         cmd_valid <= 1'b0;
         crc_err   <= 1'b0;
         cmd_index <= 6'd0;
         cmd_arg   <= 32'd0;
         shreg     <= 47'd0;
         bit_cnt   <= 6'd0;
         crc       <= 7'd0;
         ncr_cnt   <= 7'd0;
         resp_cnt  <= 6'd0;
         resp      <= 40'd0;
         resp_long <= 1'b0;
         app_cmd   <= 1'b0;
         acmd_cnt  <= 4'd0;
      end else begin
         cmd_valid <= 1'b0;
         crc_err   <= 1'b0;
         if (cs_sync[1]) begin
            // Deselected: drop any partial frame or response. Takes priority
            // over a frame completing on the same cycle.
            state   <= S_HUNT;
            sd_miso <= 1'b1;
            bit_cnt <= 6'd0;
         end else begin
            case (state)
               S_HUNT: begin
                  if (sclk_fall) sd_miso <= 1'b1;
                  if (sclk_rise && !mosi_sync[1]) begin
                     shreg   <= 47'd0;
                     bit_cnt <= 6'd1;
                     crc     <= 7'd0;     // CRC of the single 0 start bit
                     state   <= S_RECV;
                  end
               end
               S_RECV: begin
                  if (sclk_fall) sd_miso <= 1'b1;
                  if (sclk_rise) begin
                     shreg   <= {shreg[45:0], mosi_sync[1]};
                     // Bit received at count c is frame bit 47-c; CRC covers 47..8.
                     if (bit_cnt < 6'd40) crc <= crc7_step(crc, mosi_sync[1]);
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt == 6'd47) state <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (!frame_ok) begin
                     state <= S_HUNT;
                  end else begin
                     if (crc_bad) begin
                        crc_err   <= 1'b1;
                        resp      <= {4'b0000, 1'b1, 2'b00, card_idle, 32'h0};
                        resp_long <= 1'b0;
                     end else begin
                        cmd_valid <= 1'b1;
                        cmd_index <= frame_idx;
                        cmd_arg   <= frame_arg;
                        card_idle <= nxt_idle;
                        app_cmd   <= nxt_app;
                        acmd_cnt  <= nxt_cnt;
                        resp      <= nxt_resp;
                        resp_long <= nxt_long;
                     end
                     ncr_cnt <= 7'd0;
                     state   <= S_NCR;
                  end
               end
               S_NCR: begin
                  if (sclk_fall) begin
                     sd_miso <= 1'b1;
                     if (ncr_cnt == NCR_BITS - 7'd1) begin
                        resp_cnt <= 6'd0;
                        state    <= S_RESP;
                     end else begin
                        ncr_cnt <= ncr_cnt + 7'd1;
                     end
                  end
               end
               S_RESP: begin
                  if (sclk_fall) begin
                     sd_miso <= resp[39];
                     resp    <= {resp[38:0], 1'b0};
                     // Last bit stays on MISO until the next falling edge,
                     // which HUNT/RECV turn back into idle-high.
                     if (resp_cnt == resp_last) state <= S_HUNT;
                     else                       resp_cnt <= resp_cnt + 6'd1;
                  end
               end
               default: state <= S_HUNT;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_spi_card_responder
// Purpose  : Self-checking bench for sd_spi_card_responder. A host task
//            drives SPI mode-0 frames; expected responses, decoded commands
//            and CRC error pulses are queued at issue time and checked by
//            independent monitor processes.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_spi_card_responder;

   localparam int HALF    = 64;   // half sd_clk period (8 clk_sys cycles)
   localparam int NCR_EXP = 1;

   // Hand-computed frames: {01, index, arg, crc7, 1}
   localparam logic [47:0] F_CMD0     = 48'h40_0000_0000_95;
   localparam logic [47:0] F_CMD8     = 48'h48_0000_01AA_87;
   localparam logic [47:0] F_CMD0_CRC = 48'h40_0000_0000_97;  // wrong CRC, end bit 1
   localparam logic [47:0] F_CMD0_END = 48'h40_0000_0000_94;  // end bit 0
   localparam logic [47:0] F_CMD55    = 48'h77_0000_0000_65;
   localparam logic [47:0] F_ACMD41   = 48'h69_4000_0000_77;
   localparam logic [47:0] F_CMD41    = 48'h69_0000_0000_E5;
   localparam logic [47:0] F_CMD58    = 48'h7A_0000_0000_FD;
   localparam logic [47:0] F_CMD17    = 48'h51_0000_0000_55;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        sd_clk  = 1'b0;
   logic        sd_cs   = 1'b1;
   logic        sd_mosi = 1'b1;
   logic        sd_miso;
   logic        card_idle;
   logic        cmd_valid;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        crc_err;

   sd_spi_card_responder #(
      .NCR_BYTES    (1),
      .ACMD41_COUNT (2),
      .CRC_ALWAYS   (0),
      .CCS          (1)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .sd_clk    (sd_clk),
      .sd_cs     (sd_cs),
      .sd_mosi   (sd_mosi),
      .sd_miso   (sd_miso),
      .card_idle (card_idle),
      .cmd_valid (cmd_valid),
      .cmd_index (cmd_index),
      .cmd_arg   (cmd_arg),
      .crc_err   (crc_err)
   );

   always #4 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   logic [42:0] resp_q[$];     // {value, length in bytes}
   logic [37:0] cmd_q[$];      // {index, arg}
   int          crc_pending = 0;

   logic [39:0] got_val;
   int          got_len;
   int          got_ncr;
   event        resp_ev;

   task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Monitor: decoded command strobe and CRC error pulse.
   initial begin
      logic [37:0] e;
      forever begin
         @(negedge clk_sys);
         if (cmd_valid) begin
            checks++;
            if (cmd_q.size() == 0) begin
               errors++;
               $display("FAIL cmd_valid: unexpected pulse idx %0d arg %h, none required",
                        cmd_index, cmd_arg);
            end else begin
               e = cmd_q.pop_front();
               if ({cmd_index, cmd_arg} !== e) begin
                  errors++;
                  $display("FAIL cmd_decode: got idx %0d arg %h required idx %0d arg %h",
                           cmd_index, cmd_arg, e[37:32], e[31:0]);
               end
            end
         end
         if (crc_err) begin
            checks++;
            if (crc_pending == 0) begin
               errors++;
               $display("FAIL crc_err: got unexpected pulse required none");
            end else begin
               crc_pending--;
            end
         end
      end
   end

   // Monitor: responses as collected by the host.
   initial begin
      logic [42:0] e;
      forever begin
         @(resp_ev);
         checks++;
         if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL response: got unexpected %h (%0d bytes) required none", got_val, got_len);
         end else begin
            e = resp_q.pop_front();
            if (got_len != int'(e[2:0]) || got_val !== e[42:3]) begin
               errors++;
               $display("FAIL response: got %h (%0d bytes) required %h (%0d bytes)",
                        got_val, got_len, e[42:3], e[2:0]);
            end
            checks++;
            if (got_ncr != NCR_EXP) begin
               errors++;
               $display("FAIL ncr_gap: got %0d bytes required %0d", got_ncr, NCR_EXP);
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic bit_xfer(input logic b, output logic r);
      sd_mosi = b;
      #(HALF);
      r = sd_miso;
      sd_clk = 1'b1;
      #(HALF);
      sd_clk = 1'b0;
   endtask

   task automatic byte_xfer(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(tx[i], r);
         rx[i] = r;
      end
   endtask

   task automatic send_cmd(input logic [47:0] frame, input int rlen, input logic [39:0] rval,
                           input bit exp_valid, input bit exp_crc, input string name);
      logic [7:0]  b;
      logic [39:0] acc;
      bit          found;
      int          ncr;
      if (exp_valid) cmd_q.push_back({frame[45:40], frame[39:8]});
      if (exp_crc)   crc_pending++;
      if (rlen > 0)  resp_q.push_back({rval, 3'(rlen)});
      for (int k = 5; k >= 0; k--) byte_xfer(frame[k*8 +: 8], b);
      found = 1'b0;
      ncr   = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         byte_xfer(8'hFF, b);
         if (b != 8'hFF) found = 1'b1;
         else            ncr++;
      end
      if (found) begin
         acc = {32'h0, b};
         for (int k = 1; k < rlen; k++) begin
            byte_xfer(8'hFF, b);
            acc = {acc[31:0], b};
         end
         got_val = acc;
         got_len = (rlen > 0) ? rlen : 1;
         got_ncr = ncr;
         -> resp_ev;
         #1;
      end else if (rlen > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no response within 10 bytes, required %h", name, rval);
         void'(resp_q.pop_back());
      end
      byte_xfer(8'hFF, b);
   endtask

   initial begin
      logic [7:0]  b;
      logic        r;
      logic [47:0] f;

      #21;
      chk("rst_miso",      40'(sd_miso),   40'h1);
      chk("rst_card_idle", 40'(card_idle), 40'h1);
      chk("rst_cmd_valid", 40'(cmd_valid), 40'h0);
      chk("rst_crc_err",   40'(crc_err),   40'h0);
      chk("rst_cmd_index", 40'(cmd_index), 40'h0);
      chk("rst_cmd_arg",   40'(cmd_arg),   40'h0);
      #10 reset_n = 1'b1;
      repeat (5) @(negedge clk_sys);
      sd_cs = 1'b0;
      #200;

      send_cmd(F_CMD0,     1, 40'h01,            1, 0, "cmd0");
      chk("idle_after_cmd0", 40'(card_idle), 40'h1);
      send_cmd(F_CMD8,     5, 40'h01_0000_01AA,  1, 0, "cmd8");
      send_cmd(F_CMD0_CRC, 1, 40'h09,            0, 1, "cmd0_badcrc");
      send_cmd(F_CMD0_END, 0, 40'h0,             0, 0, "cmd0_badend");
      send_cmd(F_CMD41,    1, 40'h05,            1, 0, "cmd41_bare");

      send_cmd(F_CMD55,    1, 40'h01,            1, 0, "cmd55_1");
      send_cmd(F_ACMD41,   1, 40'h01,            1, 0, "acmd41_1");
      chk("idle_after_pair1", 40'(card_idle), 40'h1);
      send_cmd(F_CMD55,    1, 40'h01,            1, 0, "cmd55_2");
      send_cmd(F_ACMD41,   1, 40'h00,            1, 0, "acmd41_2");
      chk("idle_after_pair2", 40'(card_idle), 40'h0);
      send_cmd(F_CMD58,    5, 40'h00_C0FF_8000,  1, 0, "cmd58");
      send_cmd(F_CMD17,    1, 40'h04,            1, 0, "cmd17");

      // Reset while the R1 of a CMD17 is being shifted out.
      cmd_q.push_back({6'd17, 32'd0});
      f = F_CMD17;
      for (int k = 5; k >= 0; k--) byte_xfer(f[k*8 +: 8], b);
      byte_xfer(8'hFF, b);
      chk("reset_test_ncr", 40'(b), 40'hFF);
      bit_xfer(1'b1, r);
      chk("reset_test_bit7", 40'(r), 40'h0);
      bit_xfer(1'b1, r);
      #41;
      chk("pre_reset_miso", 40'(sd_miso), 40'h0);
      reset_n = 1'b0;
      #1;
      chk("reset_miso",      40'(sd_miso),   40'h1);
      chk("reset_card_idle", 40'(card_idle), 40'h1);
      chk("reset_cmd_index", 40'(cmd_index), 40'h0);
      #50 reset_n = 1'b1;
      sd_cs = 1'b1;
      #300;

      // Partial CMD8 frame aborted by CS, then a full CMD0.
      sd_cs = 1'b0;
      #200;
      f = F_CMD8;
      for (int i = 0; i < 20; i++) bit_xfer(f[47-i], r);
      sd_cs = 1'b1;
      #300;
      sd_cs = 1'b0;
      #200;
      send_cmd(F_CMD0,     1, 40'h01,            1, 0, "cmd0_after_abort");
      chk("idle_after_abort", 40'(card_idle), 40'h1);
      sd_cs = 1'b1;
      #500;

      chk("cmd_queue_empty",  40'(cmd_q.size()),  40'h0);
      chk("resp_queue_empty", 40'(resp_q.size()), 40'h0);
      chk("crc_pending_zero", 40'(crc_pending),   40'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
